// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the fetch PC generator
package fetch_pkg;
  localparam int PC_W        = 64;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that increments on en&&inc and holds at all-ones
//   clk, arst_n : clock, async active-low reset
//   en, inc     : advance enable and increment request
//   count       : saturating count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) count <= '0;
    else if (en && inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC select (redirect > BTB prediction > PC+4) with wrong-path squash
//   clk, arst_n          : clock, async active-low reset
//   en                   : pipeline advance, 0 = stall
//   predicted_branch_pc  : BTB target for prev_pc, 0 = none
//   redirect/redirect_pc : EX correction
//   current_pc, prev_pc  : fetch PC and previous enabled-cycle PC
//   squash_fetch         : current fetch is wrong-path
//   pred_taken           : prediction followed this cycle
//   pred_hits, redirects : saturating statistics
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic [PC_W-1:0]  predicted_branch_pc,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  current_pc,
  output logic [PC_W-1:0]  prev_pc,
  output logic             squash_fetch,
  output logic             pred_taken,
  output logic [CNT_W-1:0] pred_hits,
  output logic [CNT_W-1:0] redirects
);
  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, r_prev, w_pc_nxt;
  logic            r_slot_v, w_slot_v_nxt, w_use_pred, w_redir;

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) r_state <= BOOT;
    else if (en) r_state <= w_state_nxt;

  // The BTB output only describes the slot fetched last cycle, so it is usable
  // only in RUN and only when that slot was a real, non-squashed fetch.
  always_comb begin
    w_redir      = en && redirect;
    w_use_pred   = en && !redirect && r_state == RUN && r_slot_v && predicted_branch_pc != '0;
    w_pc_nxt     = w_redir ? redirect_pc : w_use_pred ? predicted_branch_pc : r_pc + PC_W'(INSTR_BYTES);
    w_state_nxt  = (w_redir || w_use_pred) ? REDIR : RUN;
    w_slot_v_nxt = !(w_redir || w_use_pred);
    squash_fetch = w_redir || w_use_pred;
    pred_taken   = w_use_pred;
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_pc     <= RESET_PC;
      r_prev   <= '0;
      r_slot_v <= 1'b0;
    end else if (en) begin
      r_pc     <= w_pc_nxt;
      r_prev   <= r_pc;
      r_slot_v <= w_slot_v_nxt;
    end

  sat_counter #(.W(CNT_W)) u_hits  (.clk(clk), .arst_n(arst_n), .en(en), .inc(w_use_pred), .count(pred_hits));
  sat_counter #(.W(CNT_W)) u_redir (.clk(clk), .arst_n(arst_n), .en(en), .inc(w_redir),    .count(redirects));

  assign current_pc = r_pc;
  assign prev_pc    = r_prev;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors with a queue scoreboard and negedge monitor
module tb_fetch_pc_gen;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic [63:0] predicted_branch_pc = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] current_pc, prev_pc;
  logic        squash_fetch, pred_taken;
  logic [1:0]  pred_hits, redirects;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] prev;
    logic        sq;
    logic        pt;
    logic [1:0]  h;
    logic [1:0]  r;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  fetch_pc_gen #(.RESET_PC(64'h100), .CNT_W(2)) dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .predicted_branch_pc(predicted_branch_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .current_pc(current_pc), .prev_pc(prev_pc),
    .squash_fetch(squash_fetch), .pred_taken(pred_taken),
    .pred_hits(pred_hits), .redirects(redirects)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("current_pc", current_pc, e.pc);
      chk("prev_pc", prev_pc, e.prev);
      chk("squash_fetch", 64'(squash_fetch), 64'(e.sq));
      chk("pred_taken", 64'(pred_taken), 64'(e.pt));
      chk("pred_hits", 64'(pred_hits), 64'(e.h));
      chk("redirects", 64'(redirects), 64'(e.r));
    end

  // Inputs change 1 time unit after a rising edge, so a reset asserted here is
  // mid-cycle and only an asynchronous reset shows up at the next negedge.
  task automatic step(input logic a, input logic e_in, input logic [63:0] pr, input logic rd,
                      input logic [63:0] rpc, input logic [63:0] pc, input logic [63:0] prev,
                      input logic sq, input logic pt, input logic [1:0] h, input logic [1:0] r);
    exp_t x;
    @(posedge clk);
    #1;
    arst_n = a;
    en = e_in;
    predicted_branch_pc = pr;
    redirect = rd;
    redirect_pc = rpc;
    x.pc = pc; x.prev = prev; x.sq = sq; x.pt = pt; x.h = h; x.r = r;
    q.push_back(x);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 64'h100, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h100, 64'h0,   0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h104, 64'h100, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h108, 64'h104, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h10C, 64'h108, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 64'h100, 64'h0,   0, 0, 0, 0);
    step(1, 1, 0,      0, 0, 64'h100, 64'h0,   0, 0, 0, 0);
    step(1, 1, 64'h200,0, 0, 64'h104, 64'h100, 1, 1, 0, 0);
    step(1, 1, 0,      0, 0, 64'h200, 64'h104, 0, 0, 1, 0);
    step(1, 1, 64'h500,1, 64'h300, 64'h204, 64'h200, 1, 0, 1, 0);
    step(1, 1, 64'h600,0, 0, 64'h300, 64'h204, 0, 0, 1, 1);
    step(1, 1, 64'h700,0, 0, 64'h304, 64'h300, 1, 1, 1, 1);
    step(1, 1, 0,      0, 0, 64'h700, 64'h304, 0, 0, 2, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 64'h800, 1, 64'h900, 64'h704, 64'h700, 0, 0, 2, 1);
    step(1, 1, 0, 0, 0, 64'h704, 64'h700, 0, 0, 2, 1);
    step(1, 1, 0, 0, 0, 64'h708, 64'h704, 0, 0, 2, 1);
    step(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h70C, 64'h708, 1, 0, 2, 1);
    step(1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h70C, 0, 0, 2, 2);
    step(1, 1, 0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 2, 2);
    step(1, 1, 0, 1, 64'h40, 64'h4,  64'h0,  1, 0, 2, 2);
    step(1, 1, 0, 1, 64'h80, 64'h40, 64'h4,  1, 0, 2, 3);
    step(1, 1, 0, 1, 64'hC0, 64'h80, 64'h40, 1, 0, 2, 3);
    step(1, 1, 64'h1000, 0, 0, 64'hC0, 64'h80, 0, 0, 2, 3);
    step(1, 1, 64'h2000, 0, 0, 64'hC4, 64'hC0, 1, 1, 2, 3);
    step(1, 1, 0,        0, 0, 64'h2000, 64'hC4, 0, 0, 3, 3);
    step(1, 1, 64'h3000, 0, 0, 64'h2004, 64'h2000, 1, 1, 3, 3);
    step(1, 1, 0,        0, 0, 64'h3000, 64'h2004, 0, 0, 3, 3);
    step(0, 0, 0, 1, 64'h5000, 64'h100, 64'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h100, 64'h0,   0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 64'h104, 64'h100, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
